mlp_param_loader: RTL and testbench

// - Writer side of the generic MLP's weights/biases buses: receives a byte-serial parameter frame, assembles it in a shadow image, commits atomically.
// - Drives weights[167:0]/biases[83:0] of the generic Iris MLP, which stays combinational and never sees a half-loaded set.
// - Sits between the test host / config channel and the MLP core; replaces testbench-driven parameters in silicon.

---
 rtl/mlp_param_loader.sv | 202 ++++++++++++++++++++
 tb/tb_mlp_param_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_param_loader.sv
// -----------------------------------------------------------------------------
// mlp_param_loader
//
// Writer side of the generic Iris MLP parameter buses. A byte-serial frame is
// assembled into a shadow image. The image is then copied onto weights/biases
// in a single cycle, so the combinational MLP never sees a half-loaded set.
//
// Frame layout: byte k fills image[8k+7:8k] (little-endian bit stream).
//   image[W_BITS-1:0]               -> weights
//   image[W_BITS+B_BITS-1:W_BITS]   -> biases
//   Upper bits of the final byte that fall beyond the image are ignored.
//
// Optional feature, macro PARAM_CHECKSUM_EN:
//   When defined, the frame carries one extra trailing byte. That byte holds
//   the mod-256 sum of the NBYTES data bytes and carries in_last.
//   A mismatch raises load_err and nothing is committed.
//   When undefined, the frame is exactly NBYTES bytes and the last data byte
//   carries in_last.
//
// Ports
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous active-high reset
//   in_valid      in   1       byte present on in_data
//   in_ready      out  1       loader accepts a byte this cycle
//   in_data       in   8       frame byte
//   in_last       in   1       final byte of frame
//   weights       out  W_BITS  committed weights
//   biases        out  B_BITS  committed biases
//   params_valid  out  1       sticky: a frame has committed since reset
//   load_done     out  1       one-cycle pulse after a commit
//   load_err      out  1       one-cycle pulse after a framing/checksum error
// -----------------------------------------------------------------------------
module mlp_param_loader #(
    parameter int W_BITS = 168,
    parameter int B_BITS = 84
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic [W_BITS-1:0] weights,
    output logic [B_BITS-1:0] biases,
    output logic              params_valid,
    output logic              load_done,
    output logic              load_err
);

    localparam int IMG_BITS  = W_BITS + B_BITS;
    localparam int NBYTES    = (IMG_BITS + 7) / 8;
    // Number of meaningful bits carried by the final data byte.
    localparam int TAIL_BITS = IMG_BITS - 8 * (NBYTES - 1);
`ifdef PARAM_CHECKSUM_EN
    localparam int FRAME_LEN = NBYTES + 1;
`else
    localparam int FRAME_LEN = NBYTES;
`endif
    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [5:0]          r_cnt;
    logic [5:0]          w_cnt_nxt;
    logic [IMG_BITS-1:0] r_img;
    logic [W_BITS-1:0]   r_weights;
    logic [B_BITS-1:0]   r_biases;
    logic                r_params_valid;
    logic                r_load_done;
    logic                r_load_err;
    logic                w_accept;
    logic                w_store;
    logic                w_err;
    logic                w_frame_ok;
`ifdef PARAM_CHECKSUM_EN
    logic [7:0]          r_sum;
`endif

    assign w_accept = in_valid & in_ready;

`ifdef PARAM_CHECKSUM_EN
    assign w_frame_ok = (in_data == r_sum);
`else
    assign w_frame_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state. r_cnt is the index of the byte being offered.
    // It is always 0 in IDLE, so IDLE and LOAD share one decision tree.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_store     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_accept) begin
                    if (r_cnt < LAST_IDX) begin
                        if (in_last) begin
                            // Frame ended early: drop the partial image.
                            w_err       = 1'b1;
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = 6'd0;
                        end else begin
                            w_store     = 1'b1;
                            w_state_nxt = S_LOAD;
                            w_cnt_nxt   = r_cnt + 6'd1;
                        end
                    end else begin
                        w_cnt_nxt = 6'd0;
                        if (!in_last) begin
                            // Frame too long: swallow bytes until in_last.
                            w_err       = 1'b1;
                            w_state_nxt = S_DRAIN;
                        end else if (w_frame_ok) begin
`ifndef PARAM_CHECKSUM_EN
                            w_store     = 1'b1;
`endif
                            w_state_nxt = S_COMMIT;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            S_DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs. The loader is held off during reset and for the single
    // commit cycle.
    always_comb begin
        in_ready = ~rst & (r_state != S_COMMIT);
    end

    // Shadow image, committed copy and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_img          <= '0;
            r_weights      <= '0;
            r_biases       <= '0;
            r_params_valid <= 1'b0;
            r_load_done    <= 1'b0;
            r_load_err     <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
            r_sum          <= 8'd0;
`endif
        end else begin
            r_load_done <= (r_state == S_COMMIT);
            r_load_err  <= w_err;
            if (w_store) begin
                for (int k = 0; k < NBYTES - 1; k++) begin
                    if (r_cnt == 6'(k)) begin
                        r_img[8*k +: 8] <= in_data;
                    end
                end
                if (r_cnt == 6'(NBYTES - 1)) begin
                    r_img[IMG_BITS-1 -: TAIL_BITS] <= in_data[TAIL_BITS-1:0];
                end
`ifdef PARAM_CHECKSUM_EN
                r_sum <= (r_cnt == 6'd0) ? in_data : r_sum + in_data;
`endif
            end
            if (r_state == S_COMMIT) begin
                r_weights      <= r_img[W_BITS-1:0];
                r_biases       <= r_img[IMG_BITS-1:W_BITS];
                r_params_valid <= 1'b1;
            end
        end
    end

    assign weights      = r_weights;
    assign biases       = r_biases;
    assign params_valid = r_params_valid;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;

endmodule

// File: tb/tb_mlp_param_loader.sv
// -----------------------------------------------------------------------------
// tb_mlp_param_loader
//
// Part 1 is a table of frame scenarios with fixed expected outcomes.
// Part 2 is a reset-mid-frame sequence.
// Part 3 is randomized frames with random bubbles, whose outcome is predicted
// from the frame-length and checksum rules. Committed values are rebuilt
// directly from the transmitted bytes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mlp_param_loader;

    localparam int W_BITS   = 168;
    localparam int B_BITS   = 84;
    localparam int IMG_BITS = W_BITS + B_BITS;
    localparam int NBYTES   = 32;
`ifdef PARAM_CHECKSUM_EN
    localparam int FLEN = NBYTES + 1;
`else
    localparam int FLEN = NBYTES;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'd0;
    logic              in_last = 1'b0;
    logic [W_BITS-1:0] weights;
    logic [B_BITS-1:0] biases;
    logic              params_valid;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    mlp_param_loader #(.W_BITS(W_BITS), .B_BITS(B_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .weights      (weights),
        .biases       (biases),
        .params_valid (params_valid),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]        fb [0:63];
    logic [W_BITS-1:0] exp_w;
    logic [B_BITS-1:0] exp_b;
    logic              exp_pv;

    typedef struct {
        int         nb;
        int         gap;
        logic [7:0] b0;
        logic [7:0] b1;
        bit         bad;
        bit         exp_commit;
        int         exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_weights"}, 256'(weights), 256'(exp_w));
        chk({tag, "_biases"}, 256'(biases), 256'(exp_b));
        chk({tag, "_params_valid"}, 256'(params_valid), 256'(exp_pv));
    endtask

    // Byte k lands at bits [8k+7:8k]; bits past the image are dropped.
    function automatic logic [IMG_BITS-1:0] img_of();
        logic [IMG_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < NBYTES; k++)
            for (int b = 0; b < 8; b++)
                if (8 * k + b < IMG_BITS) r[8*k+b] = fb[k][b];
        return r;
    endfunction

    function automatic void predict(input int nb, input bit bad, output bit c, output int e);
        if (nb < FLEN) begin
            c = 1'b0; e = nb - 1;
        end else if (nb > FLEN) begin
            c = 1'b0; e = FLEN - 1;
        end else begin
`ifdef PARAM_CHECKSUM_EN
            if (bad) begin
                c = 1'b0; e = FLEN - 1;
            end else
`endif
            begin
                c = 1'b1; e = -1;
            end
        end
    endfunction

    // Send fb[0..nb-1] with in_last on the final byte and up to gap_max idle
    // cycles before each byte. Then check the outcome.
    task automatic do_frame(input int nb, input int gap_max, input bit bad_sum,
                            input bit exp_commit, input int exp_err);
        logic [7:0]          s;
        logic [IMG_BITS-1:0] img;
        s = 8'd0;
        for (int k = 0; k < NBYTES; k++) s = s + fb[k];
`ifdef PARAM_CHECKSUM_EN
        if (nb > NBYTES) fb[NBYTES] = s + (bad_sum ? 8'd1 : 8'd0);
`endif
        for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(gap_max, 0)) step();
            in_valid = 1'b1;
            in_data  = fb[k];
            in_last  = (k == nb - 1);
            chk("in_ready_offer", 256'(in_ready), 256'(1'b1));
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'($urandom);
            chk("load_err_byte", 256'(load_err), 256'(k == exp_err));
            chk("load_done_byte", 256'(load_done), 256'(1'b0));
        end
        if (exp_commit) begin
            img = img_of();
            chk("in_ready_commit", 256'(in_ready), 256'(1'b0));
            chk("weights_precommit", 256'(weights), 256'(exp_w));
            // Offered during the commit cycle; must be ignored.
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b1;
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            exp_w  = img[W_BITS-1:0];
            exp_b  = img[IMG_BITS-1:W_BITS];
            exp_pv = 1'b1;
            chk("load_done_commit", 256'(load_done), 256'(1'b1));
            chk("load_err_commit", 256'(load_err), 256'(1'b0));
            chk("in_ready_after", 256'(in_ready), 256'(1'b1));
            chk_state("commit");
        end else begin
            step();
            chk("load_done_nocommit", 256'(load_done), 256'(1'b0));
            chk_state("hold");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit kc;
        int ke;
        int kind, nb;
        bit bad;

        // Reset behaviour
        rst = 1'b1;
        repeat (3) step();
        exp_w = '0; exp_b = '0; exp_pv = 1'b0;
        chk("rst_in_ready", 256'(in_ready), 256'(1'b0));
        chk("rst_load_done", 256'(load_done), 256'(1'b0));
        chk("rst_load_err", 256'(load_err), 256'(1'b0));
        chk_state("rst");
        rst = 1'b0;
        step();
        chk("idle_in_ready", 256'(in_ready), 256'(1'b1));
        chk_state("idle");

        // Table-driven frame scenarios
        tbl.push_back('{FLEN, 0, 8'hE3, 8'h30, 1'b0, 1'b1, -1});          // nominal
        tbl.push_back('{11, 1, 8'h55, 8'h66, 1'b0, 1'b0, 10});            // in_last on byte 10
        tbl.push_back('{FLEN, 2, 8'hA5, 8'h5A, 1'b0, 1'b1, -1});          // recovers
        tbl.push_back('{1, 0, 8'h01, 8'h02, 1'b0, 1'b0, 0});              // single-byte frame
        tbl.push_back('{40, 1, 8'h77, 8'h88, 1'b0, 1'b0, FLEN - 1});      // missing last, drain
        tbl.push_back('{FLEN - 1, 1, 8'h99, 8'hAA, 1'b0, 1'b0, FLEN - 2}); // one byte short
        tbl.push_back('{FLEN, 0, 8'h12, 8'h34, 1'b0, 1'b1, -1});          // back-to-back
`ifdef PARAM_CHECKSUM_EN
        tbl.push_back('{FLEN, 0, 8'hC3, 8'h3C, 1'b1, 1'b0, FLEN - 1});    // checksum off by 1
        tbl.push_back('{NBYTES, 0, 8'h44, 8'h45, 1'b0, 1'b0, NBYTES - 1}); // last on data byte
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < 64; k++) fb[k] = 8'(k * 7 + 3 + i * 13);
            fb[0]  = tbl[i].b0;
            fb[1]  = tbl[i].b1;
            fb[21] = 8'h7F;
            fb[22] = {fb[22][7:4], 4'h2};
            do_frame(tbl[i].nb, tbl[i].gap, tbl[i].bad, tbl[i].exp_commit, tbl[i].exp_err);
            if (i == 0) begin
                chk("nominal_w15_0", 256'(weights[15:0]), 256'(16'h30E3));
                chk("nominal_b11_0", 256'(biases[11:0]), 256'(12'h27F));
                chk("nominal_pv", 256'(params_valid), 256'(1'b1));
            end
        end

        // Reset in the middle of a frame clears everything
        for (int k = 0; k < 64; k++) fb[k] = 8'($urandom);
        for (int k = 0; k < 15; k++) begin
            in_valid = 1'b1;
            in_data  = fb[k];
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        exp_w = '0; exp_b = '0; exp_pv = 1'b0;
        chk("midrst_in_ready", 256'(in_ready), 256'(1'b0));
        chk_state("midrst");
        rst = 1'b0;
        step();
        chk("midrst_release_ready", 256'(in_ready), 256'(1'b1));
        do_frame(FLEN, 1, 1'b0, 1'b1, -1);

        // Randomized frames against the prediction rules
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 64; k++) fb[k] = 8'($urandom);
            kind = int'($urandom_range(9, 0));
            bad  = 1'b0;
            case (kind)
                6:       nb = int'($urandom_range(FLEN - 1, 1));
                7:       nb = FLEN + int'($urandom_range(6, 1));
                8: begin nb = FLEN; bad = 1'b1; end
                default: nb = FLEN;
            endcase
            predict(nb, bad, kc, ke);
            do_frame(nb, (kind == 9) ? 0 : 3, bad, kc, ke);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
